branch_resolve_unit: RTL and testbench

- Multi-cycle branch resolver for the pipelined MIPS core.
- Accepts a branch request from the D stage and waits until the forwarding network marks its operands current.
- Evaluates the branch condition and delivers a registered redirect (taken flag plus next-fetch address) to the F-stage PC logic over a valid/ready handshake.
- Replaces the single-cycle equality test on the producer side, so D can issue a branch before its operands settle.

---
 rtl/branch_resolve_unit.sv | 114 +++++++++++
 tb/tb_branch_resolve_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: multi-cycle branch resolver with operand wait and registered redirect handshake
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_pc_i,
    input  logic [15:0] req_offset_i,
    input  logic [31:0] opnd_rs_i,
    input  logic [31:0] opnd_rt_i,
    input  logic        opnd_ok_i,
    output logic        redir_valid_o,
    input  logic        redir_ready_i,
    output logic        redir_taken_o,
    output logic [31:0] redir_target_o,
    output logic        busy_o,
    output logic [15:0] stall_cycles_o
);
    typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;
    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] off_q, off_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_q, stall_d;
    logic signed [31:0] rs_s;
    logic        cond;
    logic [31:0] br_off;
    assign rs_s   = opnd_rs_i;
    assign br_off = {{14{off_q[15]}}, off_q, 2'b00};
    // Branch condition on the operands presented this cycle; codes 110/111 are never taken
    always_comb begin
        cond = op_q == 3'd0 ? opnd_rs_i == opnd_rt_i :
               op_q == 3'd1 ? opnd_rs_i != opnd_rt_i :
               op_q == 3'd2 ? rs_s <= 0 :
               op_q == 3'd3 ? rs_s > 0 :
               op_q == 3'd4 ? rs_s < 0 :
               op_q == 3'd5 ? rs_s >= 0 : 1'b0;
    end
    // Next-state logic: flush aborts everything except the stall counter
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pc_d     = pc_q;
        off_d    = off_q;
        taken_d  = taken_q;
        target_d = target_q;
        valid_d  = valid_q;
        stall_d  = stall_q;
        if (flush_i) begin
            state_d  = IDLE;
            op_d     = '0;
            pc_d     = '0;
            off_d    = '0;
            taken_d  = 1'b0;
            target_d = '0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    op_d    = req_op_i;
                    pc_d    = req_pc_i;
                    off_d   = req_offset_i;
                    state_d = WAIT;
                end
                WAIT: if (opnd_ok_i) begin
                    taken_d  = cond;
                    target_d = cond ? pc_q + 32'd4 + br_off : pc_q + 32'd8;
                    valid_d  = 1'b1;
                    state_d  = REDIR;
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
                REDIR: if (redir_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            pc_q     <= '0;
            off_q    <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
            valid_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pc_q     <= pc_d;
            off_q    <= off_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end
    assign req_ready_o    = state_q == IDLE;
    assign busy_o         = state_q != IDLE;
    assign redir_valid_o  = valid_q;
    assign redir_taken_o  = taken_q;
    assign redir_target_o = target_q;
    assign stall_cycles_o = stall_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic [2:0]  req_op = 0;
    logic [31:0] req_pc = 0;
    logic [15:0] req_offset = 0;
    logic [31:0] opnd_rs = 0;
    logic [31:0] opnd_rt = 0;
    logic        opnd_ok = 0;
    logic        redir_valid;
    logic        redir_ready = 0;
    logic        redir_taken;
    logic [31:0] redir_target;
    logic        busy;
    logic [15:0] stall_cycles;
    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;
    logic [32:0] exp_q[$];

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_pc_i(req_pc), .req_offset_i(req_offset),
        .opnd_rs_i(opnd_rs), .opnd_rt_i(opnd_rt), .opnd_ok_i(opnd_ok),
        .redir_valid_o(redir_valid), .redir_ready_i(redir_ready),
        .redir_taken_o(redir_taken), .redir_target_o(redir_target),
        .busy_o(busy), .stall_cycles_o(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] pc,
                                          input logic [15:0] off, input logic [31:0] rs, input logic [31:0] rt);
        logic t;
        int   sr;
        sr = int'(rs);
        case (op)
            3'd0: t = rs == rt;
            3'd1: t = rs != rt;
            3'd2: t = sr <= 0;
            3'd3: t = sr > 0;
            3'd4: t = sr < 0;
            3'd5: t = sr >= 0;
            default: t = 1'b0;
        endcase
        return {t, t ? pc + 32'd4 + 32'(int'($signed(off)) * 4) : pc + 32'd8};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] off,
                         input logic [31:0] rs, input logic [31:0] rt, input int nstall, input int hold);
        logic [32:0] e;
        int          lat;
        bit          got;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_op = op; req_pc = pc; req_offset = off;
        opnd_rs = rs; opnd_rt = rt; opnd_ok = 0;
        exp_q.push_back(model(op, pc, off, rs, rt));
        @(posedge clk);
        lat = 1;
        got = 0;
        for (int k = 0; k < nstall + 20 && !got; k++) begin
            @(negedge clk);
            req_valid = 0;
            opnd_ok = k >= nstall;
            @(posedge clk);
            #1;
            lat++;
            got = redir_valid;
        end
        check("redir_timeout", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(nstall + 2));
        exp_stall = exp_stall + nstall > 65535 ? 65535 : exp_stall + nstall;
        check("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        e = exp_q.pop_front();
        check("taken", 32'(redir_taken), 32'(e[32]));
        check("target", redir_target, e[31:0]);
        @(negedge clk);
        opnd_ok = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(redir_valid), 32'd1);
            check("hold_taken", 32'(redir_taken), 32'(e[32]));
            check("hold_target", redir_target, e[31:0]);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        redir_ready = 1;
        @(posedge clk);
        #1;
        check("post_valid", 32'(redir_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        redir_ready = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(redir_valid), 32'd0);
        check("rst_taken", 32'(redir_taken), 32'd0);
        check("rst_target", redir_target, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1;
        issue(3'd0, 32'h00003000, 16'h0004, 32'h12345678, 32'h12345678, 0, 0);
        check("beq_target_const", redir_target, 32'h00003014);
        issue(3'd1, 32'h00003000, 16'h0004, 32'd5, 32'd5, 3, 0);
        check("bne_stall_const", 32'(stall_cycles), 32'd3);
        for (int o = 2; o <= 5; o++) begin
            issue(3'(o), 32'h00004000, 16'h0010, 32'hFFFFFFFF, 32'd0, 0, 0);
            issue(3'(o), 32'h00004000, 16'hFFF0, 32'h00000000, 32'd7, 1, 0);
            issue(3'(o), 32'h00004000, 16'h0001, 32'h00000001, 32'd0, 0, 0);
        end
        issue(3'd0, 32'h00003000, 16'h8000, 32'd9, 32'd9, 0, 0);
        check("wrap_target_const", redir_target, 32'hFFFE3004);
        issue(3'd0, 32'h00005000, 16'h0003, 32'd1, 32'd2, 0, 4);
        issue(3'd1, 32'h00005000, 16'h0003, 32'd1, 32'd2, 2, 4);
        issue(3'd7, 32'h00006000, 16'h0020, 32'd4, 32'd4, 0, 0);
        issue(3'd6, 32'h00006000, 16'h0020, 32'hFFFFFFFF, 32'd4, 0, 0);
        // flush while waiting for operands
        @(negedge clk);
        req_valid = 1; req_op = 3'd0; req_pc = 32'h100; opnd_rs = 1; opnd_rt = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; flush = 1; opnd_ok = 1;
        @(posedge clk);
        #1;
        check("flush_wait_busy", 32'(busy), 32'd0);
        check("flush_wait_valid", 32'(redir_valid), 32'd0);
        check("flush_wait_stall", 32'(stall_cycles), 32'(exp_stall));
        @(negedge clk);
        flush = 0; opnd_ok = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_wait_no_redir", 32'(redir_valid), 32'd0);
        end
        // flush with a request in IDLE
        @(negedge clk);
        req_valid = 1; flush = 1;
        @(posedge clk);
        #1;
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_idle_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 0; flush = 0; opnd_ok = 1;
        @(posedge clk);
        #1;
        check("flush_idle_no_redir", 32'(redir_valid), 32'd0);
        @(negedge clk);
        opnd_ok = 0;
        // reset while holding a redirect
        issue(3'd0, 32'h00007000, 16'h0002, 32'd3, 32'd3, 2, 0);
        @(negedge clk);
        req_valid = 1; req_op = 3'd1; req_pc = 32'h200; opnd_rs = 1; opnd_rt = 2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; opnd_ok = 1;
        @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(redir_valid), 32'd1);
        @(negedge clk);
        opnd_ok = 0;
        #2;
        rst_n = 0;
        #1;
        check("async_reset_valid", 32'(redir_valid), 32'd0);
        check("async_reset_stall", 32'(stall_cycles), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_target", redir_target, 32'd0);
        exp_stall = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_no_redir", 32'(redir_valid), 32'd0);
        end
        issue(3'd3, 32'h00008000, 16'h0001, 32'd1, 32'd0, 70000, 0);
        check("stall_saturated", 32'(stall_cycles), 32'h0000FFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
